// File: rtl/button_if.sv
// Button pin bundle: raw pin levels in, debounced level and edge pulses out.
// The master side is the pin/board side; the slave side is the conditioner.
interface button_if #(
    parameter int NUM_CHANNELS = 1
);
    logic [NUM_CHANNELS-1:0] button_raw;
    logic [NUM_CHANNELS-1:0] button_level;
    logic [NUM_CHANNELS-1:0] button_pressed;
    logic [NUM_CHANNELS-1:0] button_released;

    modport master (
        output button_raw,
        input  button_level,
        input  button_pressed,
        input  button_released
    );

    modport slave (
        input  button_raw,
        output button_level,
        output button_pressed,
        output button_released
    );
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner: optional input inversion, an N-stage
// synchroniser, a stable-count filter and registered press/release pulses.
// Channels are fully independent. A new level is accepted only after the
// synchronised input has differed from the current level for DEBOUNCE_CYCLES
// consecutive clocks; any return to the current level restarts the count.
module button_debouncer #(
    parameter int NUM_CHANNELS     = 1,
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 1000,
    parameter int ACTIVE_LOW_INPUT = 0
) (
    input  logic    clock,
    input  logic    reset_n,
    button_if.slave btn
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_CHANNELS-1:0] INV_MASK =
        (ACTIVE_LOW_INPUT != 0) ? {NUM_CHANNELS{1'b1}} : {NUM_CHANNELS{1'b0}};

    logic [NUM_CHANNELS-1:0] in_w;
    logic [NUM_CHANNELS-1:0] sync_out;
    logic [NUM_CHANNELS-1:0] sync_q     [SYNC_STAGES];
    logic [NUM_CHANNELS-1:0] sync_d     [SYNC_STAGES];
    logic [CW-1:0]           count_q    [NUM_CHANNELS];
    logic [CW-1:0]           count_d    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] level_q,    level_d;
    logic [NUM_CHANNELS-1:0] pressed_q,  pressed_d;
    logic [NUM_CHANNELS-1:0] released_q, released_d;

    // Normalise polarity so that 1 always means "pressed" downstream.
    assign in_w     = btn.button_raw ^ INV_MASK;
    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser shift: stage 0 samples the pin, each stage feeds the next.
    always_comb begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_d[s] = '0;
        end
        sync_d[0] = in_w;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Stable-count filter and pulse generation, one lane per channel.
    always_comb begin
        level_d    = level_q;
        pressed_d  = '0;
        released_d = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            count_d[ch] = '0;
            if (sync_out[ch] != level_q[ch]) begin
                if (count_q[ch] == CNT_MAX) begin
                    // Input held long enough: accept it and flag the edge.
                    level_d[ch]    = sync_out[ch];
                    pressed_d[ch]  = sync_out[ch];
                    released_d[ch] = ~sync_out[ch];
                end else begin
                    count_d[ch] = count_q[ch] + CW'(1);
                end
            end
        end
    end

    // State registers; reset returns every channel to "released, stable".
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                count_q[ch] <= '0;
            end
            level_q    <= '0;
            pressed_q  <= '0;
            released_q <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                count_q[ch] <= count_d[ch];
            end
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign btn.button_level    = level_q;
    assign btn.button_pressed  = pressed_q;
    assign btn.button_released = released_q;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// two channels, plus a second active-low instance. Inputs change and outputs
// are sampled on the falling clock edge; "edge e" is the e-th rising edge
// after the stimulus change.
module tb_button_debouncer;
    logic clock;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    button_if #(.NUM_CHANNELS(2)) bif ();
    button_if #(.NUM_CHANNELS(2)) aif ();

    button_debouncer #(
        .NUM_CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW_INPUT(0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .btn(bif)
    );

    button_debouncer #(
        .NUM_CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW_INPUT(1)
    ) dut_al (
        .clock(clock), .reset_n(reset_n), .btn(aif)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [1:0] exp_z;
        exp_z = 2'b00;
        reset_n = 1'b1;
        bif.button_raw = 2'b11;
        aif.button_raw = 2'b11;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        if (bif.button_level !== exp_z) begin
            n_fail++; $display("FAIL reset_level_imm got=%b exp=%b", bif.button_level, exp_z);
        end
        n_checks++;
        if (bif.button_pressed !== exp_z) begin
            n_fail++; $display("FAIL reset_pressed_imm got=%b exp=%b", bif.button_pressed, exp_z);
        end
        n_checks++;
        if (bif.button_released !== exp_z) begin
            n_fail++; $display("FAIL reset_released_imm got=%b exp=%b", bif.button_released, exp_z);
        end
        n_checks++;
        if (aif.button_level !== exp_z) begin
            n_fail++; $display("FAIL reset_al_level_imm got=%b exp=%b", aif.button_level, exp_z);
        end
        n_checks++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if ({bif.button_level, bif.button_pressed, bif.button_released} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d got=%b/%b/%b exp=00/00/00", c,
                         bif.button_level, bif.button_pressed, bif.button_released);
            end
            n_checks++;
        end
        bif.button_raw = 2'b00;
        reset_n = 1'b1;
    endtask

    task automatic test_clean_press();
        logic [1:0] exp_l, exp_p;
        bif.button_raw = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clock);
            exp_l = (e >= 6) ? 2'b01 : 2'b00;
            exp_p = (e == 6) ? 2'b01 : 2'b00;
            if (bif.button_level !== exp_l) begin
                n_fail++; $display("FAIL press_level e=%0d got=%b exp=%b", e, bif.button_level, exp_l);
            end
            n_checks++;
            if (bif.button_pressed !== exp_p) begin
                n_fail++; $display("FAIL press_pulse e=%0d got=%b exp=%b", e, bif.button_pressed, exp_p);
            end
            n_checks++;
            if (bif.button_released !== 2'b00) begin
                n_fail++; $display("FAIL press_no_release e=%0d got=%b exp=00", e, bif.button_released);
            end
            n_checks++;
        end
    endtask

    task automatic test_bounce();
        logic [1:0] exp_l, exp_p, exp_r;
        // Release first so the bounce starts from level 0.
        bif.button_raw = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clock);
            exp_l = (e >= 6) ? 2'b00 : 2'b01;
            exp_r = (e == 6) ? 2'b01 : 2'b00;
            if (bif.button_level !== exp_l) begin
                n_fail++; $display("FAIL release_level e=%0d got=%b exp=%b", e, bif.button_level, exp_l);
            end
            n_checks++;
            if (bif.button_released !== exp_r) begin
                n_fail++; $display("FAIL release_pulse e=%0d got=%b exp=%b", e, bif.button_released, exp_r);
            end
            n_checks++;
        end
        // Raw 1 for edges 1-3, 0 for edge 4, 1 from edge 5: accepted at edge 10.
        for (int e = 1; e <= 12; e++) begin
            bif.button_raw = (e == 4) ? 2'b00 : 2'b01;
            @(negedge clock);
            exp_l = (e >= 10) ? 2'b01 : 2'b00;
            exp_p = (e == 10) ? 2'b01 : 2'b00;
            if (bif.button_level !== exp_l) begin
                n_fail++; $display("FAIL bounce_level e=%0d got=%b exp=%b", e, bif.button_level, exp_l);
            end
            n_checks++;
            if (bif.button_pressed !== exp_p) begin
                n_fail++; $display("FAIL bounce_pulse e=%0d got=%b exp=%b", e, bif.button_pressed, exp_p);
            end
            n_checks++;
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_l, exp_p, exp_r;
        bif.button_raw = 2'b10;
        repeat (8) @(negedge clock);
        if (bif.button_level !== 2'b10) begin
            n_fail++; $display("FAIL simul_setup got=%b exp=10", bif.button_level);
        end
        n_checks++;
        bif.button_raw = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clock);
            exp_l = (e >= 6) ? 2'b01 : 2'b10;
            exp_p = (e == 6) ? 2'b01 : 2'b00;
            exp_r = (e == 6) ? 2'b10 : 2'b00;
            if (bif.button_level !== exp_l) begin
                n_fail++; $display("FAIL simul_level e=%0d got=%b exp=%b", e, bif.button_level, exp_l);
            end
            n_checks++;
            if (bif.button_pressed !== exp_p) begin
                n_fail++; $display("FAIL simul_pressed e=%0d got=%b exp=%b", e, bif.button_pressed, exp_p);
            end
            n_checks++;
            if (bif.button_released !== exp_r) begin
                n_fail++; $display("FAIL simul_released e=%0d got=%b exp=%b", e, bif.button_released, exp_r);
            end
            n_checks++;
        end
    endtask

    task automatic test_reset_mid_count();
        logic [1:0] exp_l, exp_p;
        bif.button_raw = 2'b00;
        repeat (8) @(negedge clock);
        bif.button_raw = 2'b01;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clock);
            if ({bif.button_level, bif.button_pressed} !== 4'b0000) begin
                n_fail++;
                $display("FAIL midrst_pre e=%0d got=%b/%b exp=00/00", e, bif.button_level, bif.button_pressed);
            end
            n_checks++;
        end
        reset_n = 1'b0;
        #1;
        if (bif.button_level !== 2'b00) begin
            n_fail++; $display("FAIL midrst_in_reset got=%b exp=00", bif.button_level);
        end
        n_checks++;
        @(negedge clock);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clock);
            exp_l = (e >= 6) ? 2'b01 : 2'b00;
            exp_p = (e == 6) ? 2'b01 : 2'b00;
            if (bif.button_level !== exp_l) begin
                n_fail++; $display("FAIL midrst_level e=%0d got=%b exp=%b", e, bif.button_level, exp_l);
            end
            n_checks++;
            if (bif.button_pressed !== exp_p) begin
                n_fail++; $display("FAIL midrst_pulse e=%0d got=%b exp=%b", e, bif.button_pressed, exp_p);
            end
            n_checks++;
        end
    endtask

    task automatic test_active_low();
        logic [1:0] exp_l, exp_p;
        bif.button_raw = 2'b00;
        aif.button_raw = 2'b11;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clock);
            if ({aif.button_level, aif.button_pressed, aif.button_released} !== 6'b0) begin
                n_fail++;
                $display("FAIL al_idle e=%0d got=%b/%b/%b exp=00/00/00", e,
                         aif.button_level, aif.button_pressed, aif.button_released);
            end
            n_checks++;
        end
        aif.button_raw = 2'b10;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clock);
            exp_l = (e >= 6) ? 2'b01 : 2'b00;
            exp_p = (e == 6) ? 2'b01 : 2'b00;
            if (aif.button_level !== exp_l) begin
                n_fail++; $display("FAIL al_level e=%0d got=%b exp=%b", e, aif.button_level, exp_l);
            end
            n_checks++;
            if (aif.button_pressed !== exp_p) begin
                n_fail++; $display("FAIL al_pulse e=%0d got=%b exp=%b", e, aif.button_pressed, exp_p);
            end
            n_checks++;
            if (aif.button_released !== 2'b00) begin
                n_fail++; $display("FAIL al_no_release e=%0d got=%b exp=00", e, aif.button_released);
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_active_low();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
